// File: rtl/fib_seq_engine.sv
// fib_seq_engine: generalised Fibonacci term engine with history buffer, overflow flag and abort.
// Define FIB_SAT_EN to saturate the adder to all-ones on carry instead of wrapping.
module fib_seq_engine #(
    parameter int WIDTH      = 32,
    parameter int HIST_DEPTH = 8,
    localparam int HW        = $clog2(HIST_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_stb,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_seed0,
    input  logic [WIDTH-1:0] i_seed1,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_fib,
    output logic             o_ovf,
    input  logic [HW-1:0]    i_hist_idx,
    output logic [WIDTH-1:0] o_hist_data,
    output logic [HW:0]      o_hist_count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a, b, cnt, sum;
    logic carry, b_ovf, accept, step, done;
    logic [WIDTH-1:0] mem [HIST_DEPTH];
    logic [HW-1:0] ptr, rd_ptr;
    logic [HW:0] count;
    assign o_busy       = state == RUN;
    assign o_hist_count = count;
    assign rd_ptr       = ptr - HW'(1) - i_hist_idx;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        done     = 1'b0;
        if (state == IDLE) begin
            accept = i_stb;
            if (i_stb) state_nx = RUN;
        end else if (i_abort) state_nx = IDLE;
        else if (cnt != '0) step = 1'b1;
        else begin
            done     = 1'b1;
            state_nx = IDLE;
        end
    end
    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
`ifdef FIB_SAT_EN
        if (carry) sum = '1;
`endif
    end
    // b_ovf moves into o_ovf only when b becomes a, so the look-ahead term never flags
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            a           <= '0;
            b           <= '0;
            cnt         <= '0;
            b_ovf       <= 1'b0;
            o_ovf       <= 1'b0;
            o_fib       <= '0;
            o_valid     <= 1'b0;
            ptr         <= '0;
            count       <= '0;
            o_hist_data <= '0;
        end else begin
            o_valid     <= done;
            o_hist_data <= ({1'b0, i_hist_idx} < count) ? mem[rd_ptr] : '0;
            if (accept) begin
                a     <= i_seed0;
                b     <= i_seed1;
                b_ovf <= 1'b0;
                cnt   <= i_n;
                o_ovf <= 1'b0;
                ptr   <= '0;
                count <= '0;
            end else if (step) begin
                a     <= b;
                b     <= sum;
                cnt   <= cnt - WIDTH'(1);
                o_ovf <= o_ovf | b_ovf;
                b_ovf <= carry;
            end
            if (done) o_fib <= a;
            if (step || done) begin
                ptr   <= ptr + HW'(1);
                count <= (count == (HW+1)'(HIST_DEPTH)) ? count : count + (HW+1)'(1);
            end
        end
    always_ff @(posedge i_clk)
        if (step || done) mem[ptr] <= a;
endmodule

// File: tb/tb_fib_seq_engine.sv
// tb_fib_seq_engine: randomized and directed checks of fib_seq_engine (WIDTH=8) against a term-level model.
// Honours FIB_SAT_EN the same way as the design.
module tb_fib_seq_engine;
    logic       i_clk = 0, i_reset_n = 1, i_stb = 0, i_abort = 0;
    logic [7:0] i_n = 0, i_seed0 = 0, i_seed1 = 0;
    logic [2:0] i_hist_idx = 0;
    logic       o_busy, o_valid, o_ovf;
    logic [7:0] o_fib, o_hist_data;
    logic [3:0] o_hist_count;
    int total = 0, bad = 0;
    bit checking = 0;

    fib_seq_engine #(.WIDTH(8), .HIST_DEPTH(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_stb), .i_abort(i_abort),
        .i_n(i_n), .i_seed0(i_seed0), .i_seed1(i_seed1),
        .o_busy(o_busy), .o_valid(o_valid), .o_fib(o_fib), .o_ovf(o_ovf),
        .i_hist_idx(i_hist_idx), .o_hist_data(o_hist_data), .o_hist_count(o_hist_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // F(k) computed by plain iteration from the seeds
    function automatic logic [7:0] term(input logic [7:0] s0, input logic [7:0] s1, input int k);
        logic [8:0] x, y, z;
        x = {1'b0, s0};
        y = {1'b0, s1};
        for (int i = 0; i < k; i++) begin
            z = x + y;
`ifdef FIB_SAT_EN
            if (z[8]) z = 9'h0ff;
`endif
            z[8] = 1'b0;
            x = y;
            y = z;
        end
        return x[7:0];
    endfunction

    // whether any of F(2..j) came out of a carrying addition
    function automatic bit ovf_upto(input logic [7:0] s0, input logic [7:0] s1, input int j);
        logic [8:0] x, y, z;
        bit o;
        o = 0;
        x = {1'b0, s0};
        y = {1'b0, s1};
        for (int i = 0; i < j - 1; i++) begin
            z = x + y;
            o |= z[8];
`ifdef FIB_SAT_EN
            if (z[8]) z = 9'h0ff;
`endif
            z[8] = 1'b0;
            x = y;
            y = z;
        end
        return o;
    endfunction

    logic [7:0] m_s0 = 0, m_s1 = 0, m_n = 0, m_fib = 0, m_hd = 0;
    int  m_steps = 0, m_wrote = 0;
    bit  m_busy = 0, m_valid = 0, m_ovf = 0;

    function automatic int hcount(input int w);
        return w > 8 ? 8 : w;
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_busy = 0; m_valid = 0; m_fib = 0; m_ovf = 0; m_wrote = 0; m_hd = 0;
        end else begin
            m_hd = (int'(i_hist_idx) < hcount(m_wrote)) ? term(m_s0, m_s1, m_wrote - 1 - int'(i_hist_idx)) : 8'd0;
            m_valid = 0;
            if (!m_busy) begin
                if (i_stb) begin
                    m_s0 = i_seed0; m_s1 = i_seed1; m_n = i_n;
                    m_busy = 1; m_steps = 0; m_wrote = 0; m_ovf = 0;
                end
            end else if (i_abort) m_busy = 0;
            else if (m_steps < int'(m_n)) begin
                m_steps++;
                m_wrote++;
                m_ovf = ovf_upto(m_s0, m_s1, m_steps);
            end else begin
                m_fib = term(m_s0, m_s1, int'(m_n));
                m_valid = 1;
                m_wrote++;
                m_busy = 0;
            end
        end
    end

    always @(negedge i_clk) if (checking) begin
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("fib", 32'(o_fib), 32'(m_fib));
        chk("ovf", 32'(o_ovf), 32'(m_ovf));
        chk("hist_count", 32'(o_hist_count), 32'(hcount(m_wrote)));
        chk("hist_data", 32'(o_hist_data), 32'(m_hd));
    end

    task automatic cyc();
        @(negedge i_clk);
    endtask

    task automatic start(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] n, input bit ab);
        i_seed0 = s0; i_seed1 = s1; i_n = n; i_stb = 1; i_abort = ab;
        cyc();
        i_stb = 0; i_abort = 0;
    endtask

    task automatic wait_done(input int n, input string nm);
        int w;
        w = 1;
        cyc();
        while (!o_valid && w < n + 20) begin
            cyc();
            w++;
        end
        chk({nm, "_latency"}, 32'(w), 32'(n + 1));
    endtask

    task automatic read_hist(input logic [2:0] idx, input logic [7:0] exp, input string nm);
        i_hist_idx = idx;
        cyc();
        chk(nm, 32'(o_hist_data), 32'(exp));
    endtask

    int h10[8] = '{55, 34, 21, 13, 8, 5, 3, 2};

    initial begin
        #1 i_reset_n = 0;
        repeat (3) cyc();
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_fib", 32'(o_fib), 0);
        chk("rst_count", 32'(o_hist_count), 0);
        i_reset_n = 1;
        checking = 1;
        cyc();

        start(0, 1, 10, 0);
        wait_done(10, "fib10");
        chk("fib10_val", 32'(o_fib), 55);
        chk("fib10_ovf", 32'(o_ovf), 0);
        chk("fib10_cnt", 32'(o_hist_count), 8);
        for (int i = 0; i < 8; i++) read_hist(3'(i), 8'(h10[i]), "fib10_hist");

        start(2, 1, 0, 0);
        wait_done(0, "lucas0");
        chk("lucas0_val", 32'(o_fib), 2);
        chk("lucas0_cnt", 32'(o_hist_count), 1);
        read_hist(0, 2, "lucas0_h0");
        read_hist(1, 0, "lucas0_h1");

        start(0, 1, 13, 0);
        wait_done(13, "fib13");
        chk("fib13_val", 32'(o_fib), 233);
        chk("fib13_ovf", 32'(o_ovf), 0);
        start(0, 1, 14, 0);
        wait_done(14, "fib14");
`ifdef FIB_SAT_EN
        chk("fib14_val", 32'(o_fib), 255);
`else
        chk("fib14_val", 32'(o_fib), 121);
`endif
        chk("fib14_ovf", 32'(o_ovf), 1);

        start(0, 1, 10, 0);
        wait_done(10, "pre_abort");
        start(0, 1, 20, 0);
        cyc();
        cyc();
        i_abort = 1;
        cyc();
        i_abort = 0;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_valid", 32'(o_valid), 0);
        chk("abort_fib", 32'(o_fib), 55);
        chk("abort_cnt", 32'(o_hist_count), 2);
        start(0, 1, 1, 0);
        wait_done(1, "post_abort");
        chk("post_abort_val", 32'(o_fib), 1);

        start(0, 1, 30, 0);
        repeat (4) cyc();
        #1 i_reset_n = 0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_fib", 32'(o_fib), 0);
        chk("mid_rst_ovf", 32'(o_ovf), 0);
        chk("mid_rst_hdata", 32'(o_hist_data), 0);
        chk("mid_rst_cnt", 32'(o_hist_count), 0);
        cyc();
        i_reset_n = 1;
        cyc();
        start(0, 1, 12, 0);
        cyc();
        i_stb = 1; i_n = 3; i_seed0 = 7; i_seed1 = 9;
        repeat (4) cyc();
        i_stb = 0;
        wait_done(12 - 5, "busy_stb");
        chk("busy_stb_val", 32'(o_fib), 144);

        start(0, 1, 255, 0);
        wait_done(255, "n_max");
        chk("n_max_ovf", 32'(o_ovf), 1);

        for (int r = 0; r < 300; r++) begin
            int n, ab, c;
            n = $urandom_range(0, 20);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 1) : 0;
            start(8'($urandom), 8'($urandom), 8'(n), $urandom_range(0, 3) == 0);
            c = 1;
            while (o_busy && c < 400) begin
                i_abort = (c == ab);
                i_stb = ($urandom_range(0, 3) == 0);
                i_n = 8'($urandom); i_seed0 = 8'($urandom); i_seed1 = 8'($urandom);
                i_hist_idx = 3'($urandom);
                cyc();
                c++;
            end
            i_abort = 0; i_stb = 0;
            if (c >= 400) chk("rand_timeout", 32'(c), 0);
            repeat ($urandom_range(0, 2)) begin
                i_hist_idx = 3'($urandom);
                cyc();
            end
        end
        cyc();
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fib_seq_engine.md
# fib_seq_engine

Parametrised successor to the single-channel Fibonacci iterator. It computes term F(n) of a generalised Fibonacci-type sequence, F(k+2)=F(k+1)+F(k), from caller-supplied seeds F(0) and F(1), so Fibonacci (0,1) and Lucas (2,1) come from the same hardware. It keeps a readable history of the last HIST_DEPTH terms, reports arithmetic overflow, and supports abort. It sits behind a register/strobe front end as a multi-cycle arithmetic unit.

## Interface
- WIDTH, 32: term, seed and n width in bits.
- HIST_DEPTH, 8: history entries. Must be a power of two, ≥2. HW = $clog2(HIST_DEPTH).
- i_clk  in  1  clock; all state changes on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_stb  in  1  start request; accepted only when o_busy=0.
- i_abort  in  1  cancels the run in progress; ignored when idle.
- i_n  in  WIDTH  index of the requested term; sampled on accept.
- i_seed0  in  WIDTH  F(0); sampled on accept.
- i_seed1  in  WIDTH  F(1); sampled on accept.
- o_busy  out  1  high while a run is in progress.
- o_valid  out  1  one-cycle pulse when o_fib updates with a result.
- o_fib  out  WIDTH  last completed F(n); holds until the next completion.
- o_ovf  out  1  at least one term F(0..n) of the current/last run overflowed WIDTH.
- i_hist_idx  in  HW  history read index; 0 = most recent term.
- o_hist_data  out  WIDTH  registered history read data.
- o_hist_count  out  HW+1  number of valid history entries, 0..HIST_DEPTH.

## Operation
- Datapath: a=F(k), b=F(k+1), cnt=n−k. An overflow bit b_ovf travels with b.
- States: IDLE, RUN. o_busy = (state==RUN).
- IDLE with i_stb: a←i_seed0, b←i_seed1, b_ovf←0, cnt←i_n, o_ovf←0. History ptr and count clear to 0. Go to RUN.
- RUN with cnt≠0: a←b, b←a+b, cnt←cnt−1. Write a into the history at ptr. ptr increments modulo HIST_DEPTH. Count increments, saturating at HIST_DEPTH. o_ovf ←o_ovf|b_ovf. b_ovf←carry of a+b.
- RUN with cnt==0: o_fib←a, o_valid←1, write a into the history the same way, go to IDLE.
- Overflow of the look-ahead term F(n+1) never sets o_ovf.
- i_abort in RUN takes priority over stepping. Go to IDLE. No o_valid. o_fib unchanged. History and o_ovf keep their partial contents.
- i_stb while busy is ignored. i_abort and i_stb together in IDLE: the strobe is accepted.
- History read: o_hist_data ← entry (ptr−1−i_hist_idx) mod HIST_DEPTH when i_hist_idx < count, otherwise 0.

## Timing
- Accept edge E0. Edges E1..En step. Edge E(n+1) completes.
- o_valid is high during the cycle after E(n+1), which is n+1 cycles after accept. o_busy falls at that same edge.
- i_n=0: completion on E1, o_fib=seed0, history holds 1 entry.
- Earliest next accept: the edge ending the o_valid cycle. The engine is back-to-back capable with no dead cycle beyond o_valid.
- History read latency: 1 cycle. A read in the same cycle as a write returns the pre-write contents.
- Reset, which may assert mid-run: o_busy, o_valid, o_fib, o_ovf, o_hist_data and o_hist_count go to 0 immediately, without a clock edge. State goes to IDLE. Buffer RAM is not cleared, because count gating hides it.
- cnt uses WIDTH bits. i_n=2^WIDTH−1 is legal, and the run takes 2^WIDTH cycles.

## Configuration
- FIB_SAT_EN defined: a+b saturates to all-ones on carry. o_ovf behaves as described above.
- FIB_SAT_EN undefined: a+b wraps modulo 2^WIDTH. o_ovf behaves identically.

## Test plan
- WIDTH=32, seeds 0/1, n=10 → o_valid 11 cycles after accept; o_fib=55; o_ovf=0; hist idx0..7 = 55,34,21,13,8,5,3,2; count=8.
- Seeds 2/1, n=0 → o_fib=2 one cycle after accept; count=1; idx0=2; idx1 reads 0.
- WIDTH=8, seeds 0/1: n=13 → 233, o_ovf=0. n=14 → wrap build 121, sat build 255, o_ovf=1 in both.
- n=20 with i_abort on the 3rd RUN cycle (o_fib=55 from a prior run) → o_busy low next edge, no o_valid, o_fib=55. A new i_stb the following cycle with n=1 → o_fib=1.
- Deassert i_reset_n mid-run between clock edges → all outputs read 0 before the next edge. After release, i_stb raised while busy is ignored, and the result matches a single run.
